// File: rtl/unsigned_seq_div_restoring.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock MSB first, giving a 2N-bit quotient and N-bit remainder.
module unsigned_seq_div_restoring #(
  parameter int N = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N:0]     r;
  logic [2*N-1:0] q;
  logic [N-1:0]   d;
  logic [CW-1:0]  cnt;

  logic [N:0]     trial;
  logic           fits;
  logic [N:0]     r_next;
  logic [2*N-1:0] q_next;
  logic           last_iter;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    trial     = {r[N-1:0], q[2*N-1]};
    fits      = (trial >= {1'b0, d});
    r_next    = fits ? (trial - {1'b0, d}) : trial;
    q_next    = {q[2*N-2:0], fits};
    last_iter = (cnt == CW'(2*N-1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            q           <= dividend;
            d           <= divisor;
            r           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            busy        <= (divisor != '0);
            state       <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // A zero divisor gets a single non-iterating publish cycle with busy low.
          if (d == '0) begin
            quotient    <= '1;
            remainder   <= q[N-1:0];
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              quotient  <= q_next;
              remainder <= r_next[N-1:0];
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
